decode_stage: RTL
=================

# decode_stage

Parametrised, handshaked CHIP-8 instruction decode stage sitting between the fetch unit and the execute unit. Accepts raw 16-bit instructions with their PC, decodes them into an opcode ID plus operand fields, and buffers decoded records in a small FIFO so that fetch and execute can stall independently. Supports an optional SUPER-CHIP opcode set, flags illegal encodings, and discards all buffered work on a flush, which is raised when a branch or jump is taken.

## Interface
- ADDR_W, 12: width of the address operand and the PC (12 for CHIP-8, 16 for XO-style extensions).
- DEPTH, 2: FIFO entries. Must be a power of two and at least 1.
- SCHIP, 0: 1 enables decoding of the SUPER-CHIP opcodes. When 0, those encodings are illegal.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries and any input accepted this cycle.
- in_valid  in  1  instruction present.
- in_ready  out  1  stage can accept (= !full).
- instruction  in  16  raw opcode, MSB first.
- in_pc  in  ADDR_W  address of the instruction.
- out_valid  out  1  decoded record at head.
- out_ready  in  1  execute consumes head.
- op  out  6  opcode ID (chip8_pkg).
- x, y, nib  out  4 each  instruction[11:8], [7:4], [3:0] when used, else 0.
- val  out  8  instruction[7:0] when used, else 0.
- addr  out  ADDR_W  zero-extended instruction[11:0] when used, else 0.
- pc  out  ADDR_W  PC of the head record.
- illegal  out  1  head record is an undefined encoding (op = 0).

## Operation
- Decode is combinational on the input side. The record {op, x, y, nib, val, addr, pc, illegal} is written into the FIFO on the handshake in_valid && in_ready && !flush.
- Field rules:
  - 1nnn, 2nnn, Annn, Bnnn: addr only.
  - 3xkk, 4xkk, 6xkk, 7xkk, Cxkk: x and val.
  - 5xy0, 9xy0, 8xyN: x and y.
  - Dxyn: x, y and nib.
  - Ex__, Fx__: x only.
  - Unused fields are driven to 0.
- Opcode IDs: 1–30 as currently allocated. 31 is reserved. 32–35 are LD_F, LD_B, STORE_REG and READ_REG.
- SUPER-CHIP IDs, decoded only when SCHIP=1:
  - 36 SCD (00Cn, nib=n)
  - 37 SCR (00FB)
  - 38 SCL (00FC)
  - 39 EXIT (00FD)
  - 40 LOW (00FE)
  - 41 HIGH (00FF)
  - 42 DRW16 (Dxy0)
  - 43 LD_HF (Fx30)
  - 44 STORE_RPL (Fx75)
  - 45 READ_RPL (Fx85)
- Illegal encodings produce op=0 and illegal=1. These are:
  - 0nnn other than 00E0 and 00EE (and, when SCHIP=1, the 00Cn/00Fx forms above);
  - 5xyN or 9xyN with N≠0;
  - 8xyN with N ∉ {0–7, E};
  - Ex__ other than 9E/A1;
  - Fx__ not listed.
- Illegal records are still buffered and presented, so execute can trap.
- With SCHIP=0, Dxy0 decodes as DRW with nib=0.
- FIFO: circular, pointer width log2(DEPTH)+1. Full when the pointers differ only in the MSB. Empty when the pointers are equal.
- The head fields are driven directly from the storage at the read pointer and are valid whenever out_valid=1. When out_valid=0 the head fields read 0.

## Timing
- Reset: all outputs are 0, out_valid=0, in_ready=1, and both pointers are 0.
- Latency: an instruction accepted in cycle t appears at the head in cycle t+1 if the FIFO was empty.
- Throughput: one instruction per cycle when out_ready is held high.
- Full: in_ready=0. A simultaneous pop does not raise in_ready in the same cycle, so there is no combinational ready path.
- Empty: out_valid=0, and out_ready is ignored.
- Push and pop in the same cycle: both happen, and the count is unchanged.
- Flush: on the next edge both pointers are reset to 0. Any push in the flush cycle is dropped, and any pop in the flush cycle is a no-op. out_valid=0 in the cycle after the flush.
- rst asserted mid-stream: same effect as flush, and it also clears storage to 0.
- Pointer wrap-around at DEPTH is seamless, with no bubble.
- A holding record (out_valid && !out_ready) must stay stable, bit for bit, until it is consumed or flushed.

## Structure
- chip8_pkg holds:
  - the opcode ID localparams (0–45, including OP_ILLEGAL=0);
  - the field-extraction width constants;
  - a function `chip8_decode(instr, schip)` returning the packed record. The execute unit reuses the same IDs.
- One sub-module, decode_fifo: a generic DEPTH×W synchronous FIFO with flush, instantiated with W = 6+4+4+4+8+2·ADDR_W+1.
- decode_stage contains the decode function call, the FIFO instance and the handshake glue.

## Test plan
- Reset, then push 00E0, 1234 and 8AB4 back-to-back with out_ready=1. Outputs appear on cycles 1–3:
  - op=1;
  - op=3, addr=0x234;
  - op=14, x=0xA, y=0xB.
- DEPTH=2, out_ready=0, push three instructions. in_ready goes 0 after the second push and the third is not accepted. Then pulse out_ready once: in_ready returns to 1 on the next cycle.
- Push C3F0 then D125. Outputs are op=22, x=3, val=0xF0, then op=23, x=1, y=2, nib=5.
- SCHIP=0, push 00FF. Output is op=0, illegal=1. With SCHIP=1 the same input gives op=41, illegal=0.
- Fill the FIFO and assert flush together with in_valid. Next cycle out_valid=0. The dropped input never appears.
- Stream 10 instructions with random out_ready stalls and DEPTH=4. Every record emerges in order with the correct pc, and a held record is stable across stall cycles.

Source files
------------

// File: rtl/chip8_pkg.sv
// CHIP-8 / SUPER-CHIP opcode IDs, decoded-record layout and the shared decode function.
package chip8_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IMM_W   = 12;

  localparam logic [OP_W-1:0] OP_ILLEGAL     = 6'd0;
  localparam logic [OP_W-1:0] OP_CLS         = 6'd1;
  localparam logic [OP_W-1:0] OP_RET         = 6'd2;
  localparam logic [OP_W-1:0] OP_JP          = 6'd3;
  localparam logic [OP_W-1:0] OP_CALL        = 6'd4;
  localparam logic [OP_W-1:0] OP_SE_VX_BYTE  = 6'd5;
  localparam logic [OP_W-1:0] OP_SNE_VX_BYTE = 6'd6;
  localparam logic [OP_W-1:0] OP_SE_VX_VY    = 6'd7;
  localparam logic [OP_W-1:0] OP_LD_VX_BYTE  = 6'd8;
  localparam logic [OP_W-1:0] OP_ADD_VX_BYTE = 6'd9;
  localparam logic [OP_W-1:0] OP_LD_VX_VY    = 6'd10;
  localparam logic [OP_W-1:0] OP_OR          = 6'd11;
  localparam logic [OP_W-1:0] OP_AND         = 6'd12;
  localparam logic [OP_W-1:0] OP_XOR         = 6'd13;
  localparam logic [OP_W-1:0] OP_ADD_VX_VY   = 6'd14;
  localparam logic [OP_W-1:0] OP_SUB         = 6'd15;
  localparam logic [OP_W-1:0] OP_SHR         = 6'd16;
  localparam logic [OP_W-1:0] OP_SUBN        = 6'd17;
  localparam logic [OP_W-1:0] OP_SHL         = 6'd18;
  localparam logic [OP_W-1:0] OP_SNE_VX_VY   = 6'd19;
  localparam logic [OP_W-1:0] OP_LD_I        = 6'd20;
  localparam logic [OP_W-1:0] OP_JP_V0       = 6'd21;
  localparam logic [OP_W-1:0] OP_RND         = 6'd22;
  localparam logic [OP_W-1:0] OP_DRW         = 6'd23;
  localparam logic [OP_W-1:0] OP_SKP         = 6'd24;
  localparam logic [OP_W-1:0] OP_SKNP        = 6'd25;
  localparam logic [OP_W-1:0] OP_LD_VX_DT    = 6'd26;
  localparam logic [OP_W-1:0] OP_LD_VX_K     = 6'd27;
  localparam logic [OP_W-1:0] OP_LD_DT_VX    = 6'd28;
  localparam logic [OP_W-1:0] OP_LD_ST_VX    = 6'd29;
  localparam logic [OP_W-1:0] OP_ADD_I_VX    = 6'd30;
  localparam logic [OP_W-1:0] OP_RESERVED    = 6'd31;
  localparam logic [OP_W-1:0] OP_LD_F        = 6'd32;
  localparam logic [OP_W-1:0] OP_LD_B        = 6'd33;
  localparam logic [OP_W-1:0] OP_STORE_REG   = 6'd34;
  localparam logic [OP_W-1:0] OP_READ_REG    = 6'd35;
  localparam logic [OP_W-1:0] OP_SCD         = 6'd36;
  localparam logic [OP_W-1:0] OP_SCR         = 6'd37;
  localparam logic [OP_W-1:0] OP_SCL         = 6'd38;
  localparam logic [OP_W-1:0] OP_EXIT        = 6'd39;
  localparam logic [OP_W-1:0] OP_LOW         = 6'd40;
  localparam logic [OP_W-1:0] OP_HIGH        = 6'd41;
  localparam logic [OP_W-1:0] OP_DRW16       = 6'd42;
  localparam logic [OP_W-1:0] OP_LD_HF       = 6'd43;
  localparam logic [OP_W-1:0] OP_STORE_RPL   = 6'd44;
  localparam logic [OP_W-1:0] OP_READ_RPL    = 6'd45;

  // Decoded fields; the PC is appended by the stage since its width is a parameter there.
  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [REG_W-1:0]  x;
    logic [REG_W-1:0]  y;
    logic [NIB_W-1:0]  nib;
    logic [BYTE_W-1:0] val;
    logic [IMM_W-1:0]  addr;
    logic              illegal;
  } dec_t;

  // Map a raw opcode to its ID; fields the opcode does not use (or any illegal encoding) read 0.
  function automatic dec_t chip8_decode(input logic [INSTR_W-1:0] instr, input logic schip);
    dec_t            r;
    logic [OP_W-1:0] op;
    logic            ux, uy, un, uv, ua, ill;
    op = OP_ILLEGAL;
    ux = 1'b0; uy = 1'b0; un = 1'b0; uv = 1'b0; ua = 1'b0;
    case (instr[15:12])
      4'h0: begin
        case (instr[11:0])
          12'h0E0: op = OP_CLS;
          12'h0EE: op = OP_RET;
          12'h0FB: if (schip) op = OP_SCR;
          12'h0FC: if (schip) op = OP_SCL;
          12'h0FD: if (schip) op = OP_EXIT;
          12'h0FE: if (schip) op = OP_LOW;
          12'h0FF: if (schip) op = OP_HIGH;
          default: if (schip && instr[11:4] == 8'h0C) begin op = OP_SCD; un = 1'b1; end
        endcase
      end
      4'h1: begin op = OP_JP;          ua = 1'b1; end
      4'h2: begin op = OP_CALL;        ua = 1'b1; end
      4'h3: begin op = OP_SE_VX_BYTE;  ux = 1'b1; uv = 1'b1; end
      4'h4: begin op = OP_SNE_VX_BYTE; ux = 1'b1; uv = 1'b1; end
      4'h5: begin
        ux = 1'b1; uy = 1'b1;
        if (instr[3:0] == 4'h0) op = OP_SE_VX_VY;
      end
      4'h6: begin op = OP_LD_VX_BYTE;  ux = 1'b1; uv = 1'b1; end
      4'h7: begin op = OP_ADD_VX_BYTE; ux = 1'b1; uv = 1'b1; end
      4'h8: begin
        ux = 1'b1; uy = 1'b1;
        if (!instr[3])                op = OP_LD_VX_VY + OP_W'(instr[2:0]);
        else if (instr[3:0] == 4'hE)  op = OP_SHL;
      end
      4'h9: begin
        ux = 1'b1; uy = 1'b1;
        if (instr[3:0] == 4'h0) op = OP_SNE_VX_VY;
      end
      4'hA: begin op = OP_LD_I;  ua = 1'b1; end
      4'hB: begin op = OP_JP_V0; ua = 1'b1; end
      4'hC: begin op = OP_RND;   ux = 1'b1; uv = 1'b1; end
      4'hD: begin
        op = (schip && instr[3:0] == 4'h0) ? OP_DRW16 : OP_DRW;
        ux = 1'b1; uy = 1'b1; un = 1'b1;
      end
      4'hE: begin
        ux = 1'b1;
        case (instr[7:0])
          8'h9E:   op = OP_SKP;
          8'hA1:   op = OP_SKNP;
          default: ;
        endcase
      end
      default: begin
        ux = 1'b1;
        case (instr[7:0])
          8'h07:   op = OP_LD_VX_DT;
          8'h0A:   op = OP_LD_VX_K;
          8'h15:   op = OP_LD_DT_VX;
          8'h18:   op = OP_LD_ST_VX;
          8'h1E:   op = OP_ADD_I_VX;
          8'h29:   op = OP_LD_F;
          8'h33:   op = OP_LD_B;
          8'h55:   op = OP_STORE_REG;
          8'h65:   op = OP_READ_REG;
          8'h30:   if (schip) op = OP_LD_HF;
          8'h75:   if (schip) op = OP_STORE_RPL;
          8'h85:   if (schip) op = OP_READ_RPL;
          default: ;
        endcase
      end
    endcase
    ill       = (op == OP_ILLEGAL);
    r.op      = op;
    r.illegal = ill;
    r.x       = (ux && !ill) ? instr[11:8] : '0;
    r.y       = (uy && !ill) ? instr[7:4]  : '0;
    r.nib     = (un && !ill) ? instr[3:0]  : '0;
    r.val     = (uv && !ill) ? instr[7:0]  : '0;
    r.addr    = (ua && !ill) ? instr[11:0] : '0;
    return r;
  endfunction

endpackage

// File: rtl/decode_fifo.sv
// Generic DEPTH x W circular FIFO with flush; head reads 0 while empty.
module decode_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = $clog2(DEPTH) + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [AW-1:0] w_widx, w_ridx;
  logic          w_do_push, w_do_pop;

  // Pointer-to-slot mapping; the extra MSB distinguishes full from empty.
  assign w_widx    = AW'(r_wptr % PW'(DEPTH));
  assign w_ridx    = AW'(r_rptr % PW'(DEPTH));
  assign o_full    = ((r_wptr ^ r_rptr) == PW'(DEPTH));
  assign o_empty   = (r_wptr == r_rptr);
  assign w_do_push = i_push && !o_full && !flush;
  assign w_do_pop  = i_pop && !o_empty && !flush;
  assign o_rdata   = o_empty ? '0 : r_mem[w_ridx];

  // Pointer update; flush and reset both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
    end
  end

  // Storage write; reset also scrubs the contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (w_do_push) begin
      r_mem[w_widx] <= i_wdata;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// CHIP-8 decode stage: combinational decode in front of a flushable record FIFO.
module decode_stage
  import chip8_pkg::*;
#(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DEPTH  = 2,
  parameter bit          SCHIP  = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [ADDR_W-1:0]  in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OP_W-1:0]    op,
  output logic [REG_W-1:0]   x,
  output logic [REG_W-1:0]   y,
  output logic [NIB_W-1:0]   nib,
  output logic [BYTE_W-1:0]  val,
  output logic [ADDR_W-1:0]  addr,
  output logic [ADDR_W-1:0]  pc,
  output logic               illegal
);

  localparam int unsigned REC_W = OP_W + 2 * REG_W + NIB_W + BYTE_W + 2 * ADDR_W + 1;

  dec_t             w_dec;
  logic [REC_W-1:0] w_wdata, w_rdata;
  logic             w_full, w_empty, w_push, w_pop;

  // Decode the incoming instruction and pack it with its PC.
  assign w_dec   = chip8_decode(instruction, SCHIP);
  assign w_wdata = {w_dec.op, w_dec.x, w_dec.y, w_dec.nib, w_dec.val,
                    ADDR_W'(w_dec.addr), in_pc, w_dec.illegal};

  // Handshake glue; ready depends only on the pointers, never on out_ready.
  assign in_ready  = !w_full;
  assign out_valid = !w_empty;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  decode_fifo #(
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign {op, x, y, nib, val, addr, pc, illegal} = w_rdata;

endmodule
